// File: rtl/mips_mc_pkg.sv
// rtl/mips_mc_pkg.sv - opcode/funct constants, FSM and ALU enums for the multicycle MIPS core
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC,
    ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alu_op_t;

  function automatic logic funct_legal(input logic [5:0] funct);
    logic ok;
    ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
         (funct == FN_OR)  || (funct == FN_SLT);
    return ok;
  endfunction

  function automatic alu_op_t funct_to_alu(input logic [5:0] funct);
    alu_op_t op;
    case (funct)
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SLT:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - main control FSM; memory states wait for mem_ready
module mips_mc_ctrl
  import mips_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output state_t     state
);

  state_t next;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      FETCH:  if (mem_ready) next = DECODE;
      DECODE: begin
        case (opcode)
          OP_RTYPE:     next = funct_legal(funct) ? EXEC : HALT;
          OP_LW, OP_SW: next = MEMADR;
          OP_BEQ:       next = BRANCH;
          OP_ADDI:      next = ADDIEX;
          OP_J:         next = JUMP;
          default:      next = HALT;
        endcase
      end
      MEMADR: next = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (mem_ready) next = MEMWB;
      MEMWR:  if (mem_ready) next = FETCH;
      EXEC:   next = ALUWB;
      ADDIEX: next = ADDIWB;
      MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: next = FETCH;
      HALT:   next = HALT;
      default: next = FETCH;
    endcase
  end

endmodule

// File: rtl/mips_mc.sv
// rtl/mips_mc.sv - multicycle MIPS core: datapath, register file and ALU around mips_mc_ctrl
module mips_mc
  import mips_mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          RF_CLEAR = 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic        halted
);

  state_t      state;
  logic [31:0] ir, a, b, alu_out, mdr;
  logic [31:0] rf [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [25:0] target;
  logic [31:0] imm_ext, rs_val, rt_val;

  assign opcode  = ir[31:26];
  assign target  = ir[25:0];
  assign rs      = ir[25:21];
  assign rt      = ir[20:16];
  assign rd      = ir[15:11];
  assign funct   = ir[5:0];
  assign imm_ext = {{16{ir[15]}}, ir[15:0]};
  assign rs_val  = (rs == 5'd0) ? 32'd0 : rf[rs];
  assign rt_val  = (rt == 5'd0) ? 32'd0 : rf[rt];
  assign halted  = (state == HALT);

  mips_mc_ctrl u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .funct     (funct),
    .mem_ready (mem_ready),
    .state     (state)
  );

  // One shared ALU: branch target in DECODE, funct op in EXEC, A+imm otherwise
  alu_op_t     alu_op;
  logic [31:0] alu_x, alu_y, alu_res;

  always_comb begin
    alu_op = ALU_ADD;
    alu_x  = a;
    alu_y  = imm_ext;
    case (state)
      DECODE: begin
        alu_x = pc;
        alu_y = {imm_ext[29:0], 2'b00};
      end
      EXEC: begin
        alu_y  = b;
        alu_op = funct_to_alu(funct);
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_res = 32'd0;
    case (alu_op)
      ALU_ADD: alu_res = alu_x + alu_y;
      ALU_SUB: alu_res = alu_x - alu_y;
      ALU_AND: alu_res = alu_x & alu_y;
      ALU_OR:  alu_res = alu_x | alu_y;
      ALU_SLT: alu_res = {31'd0, $signed(alu_x) < $signed(alu_y)};
      default: alu_res = 32'd0;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc;
    mem_wdata = b;
    case (state)
      FETCH: mem_req = 1'b1;
      MEMRD: begin
        mem_req  = 1'b1;
        mem_addr = alu_out;
      end
      MEMWR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = alu_out;
      end
      default: ;
    endcase
    // Reset abandons any in-flight transfer, so the request must drop with it
    if (reset) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
    end
  end

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = alu_out;
    case (state)
      MEMWB: begin
        rf_we    = 1'b1;
        rf_wdata = mdr;
      end
      ALUWB: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
      end
      ADDIWB: rf_we = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if (RF_CLEAR != 0) begin
        for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
      end
    end else if (rf_we && rf_waddr != 5'd0) begin
      rf[rf_waddr] <= rf_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      ir      <= 32'd0;
      a       <= 32'd0;
      b       <= 32'd0;
      alu_out <= 32'd0;
      mdr     <= 32'd0;
    end else begin
      case (state)
        FETCH: if (mem_ready) begin
          ir <= mem_rdata;
          pc <= pc + 32'd4;
        end
        DECODE: begin
          a       <= rs_val;
          b       <= rt_val;
          alu_out <= alu_res;
        end
        MEMADR, EXEC, ADDIEX: alu_out <= alu_res;
        MEMRD:  if (mem_ready) mdr <= mem_rdata;
        BRANCH: if (a == b) pc <= alu_out;
        JUMP:   pc <= {pc[31:28], target, 2'b00};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mc.sv
// tb/tb_mips_mc.sv - self-checking bench for mips_mc against an instruction-level reference model
module tb_mips_mc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, halted;
  logic        mem_ready = 1'b1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

  int checks = 0;
  int failures = 0;
  int ready_mode = 0;  // 0: always ready, 1: random stalls, 2: driven by the test

  logic [31:0] mem   [0:1023];
  logic [31:0] m_mem [0:1023];
  logic [31:0] m_rf  [0:31];
  logic [31:0] rd_addr_q[$], wr_addr_q[$], wr_data_q[$];
  logic [31:0] m_rd_q[$], m_wr_addr_q[$], m_wr_data_q[$];

  localparam logic [31:0] HALT_WORD = 32'hfc00_0000;

  mips_mc #(.RESET_PC(32'h0000_0000), .RF_CLEAR(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .pc        (pc),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[11:2]];

  // Memory responder: ready chosen on the falling edge, transfer resolved just before the rising edge
  logic        prev_wait = 1'b0, p_we = 1'b0;
  logic [31:0] p_addr = '0, p_wdata = '0;
  always @(negedge clk) begin
    if (ready_mode == 0)      mem_ready = 1'b1;
    else if (ready_mode == 1) mem_ready = ($urandom_range(0, 2) != 0);
    #4;
    if (prev_wait && !reset) begin
      checks++;
      if (!(mem_req === 1'b1 && mem_addr === p_addr && mem_we === p_we &&
            (!p_we || mem_wdata === p_wdata))) begin
        failures++;
        $display("FAIL hold_stable req=%b addr=%h we=%b wdata=%h required addr=%h we=%b wdata=%h",
                 mem_req, mem_addr, mem_we, mem_wdata, p_addr, p_we, p_wdata);
      end
    end
    if (mem_req === 1'b1 && mem_ready) begin
      if (mem_we) begin
        mem[mem_addr[11:2]] = mem_wdata;
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_wdata);
      end else begin
        rd_addr_q.push_back(mem_addr);
      end
    end
    prev_wait = (mem_req === 1'b1) && !mem_ready && !reset;
    p_addr    = mem_addr;
    p_we      = mem_we;
    p_wdata   = mem_wdata;
  end

  function automatic logic [31:0] enc_r(input logic [31:0] fn, input logic [31:0] s,
                                        input logic [31:0] t, input logic [31:0] d);
    return {6'h00, s[4:0], t[4:0], d[4:0], 5'h00, fn[5:0]};
  endfunction

  function automatic logic [31:0] enc_i(input logic [31:0] op, input logic [31:0] s,
                                        input logic [31:0] t, input logic [31:0] imm);
    return {op[5:0], s[4:0], t[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] tgt);
    return {6'h02, tgt[25:0]};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
  endtask

  // Instruction-set model: architectural effects plus the per-class cycle cost with an always-ready memory
  task automatic model_run(output int cyc);
    logic [31:0] mpc, w, x, y, r, se, ad;
    bit done;
    int steps;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_rd_q.delete(); m_wr_addr_q.delete(); m_wr_data_q.delete();
    mpc = 32'd0; cyc = 0; done = 0; steps = 0;
    while (!done && steps < 500) begin
      w = m_mem[mpc[11:2]];
      m_rd_q.push_back(mpc);
      mpc = mpc + 4;
      steps++;
      x  = m_rf[w[25:21]];
      y  = m_rf[w[20:16]];
      se = {{16{w[15]}}, w[15:0]};
      ad = x + se;
      r  = 32'd0;
      case (w[31:26])
        6'h00: begin
          case (w[5:0])
            6'h20: r = x + y;
            6'h22: r = x - y;
            6'h24: r = x & y;
            6'h25: r = x | y;
            6'h2a: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: done = 1;
          endcase
          if (!done) begin
            if (w[15:11] != 0) m_rf[w[15:11]] = r;
            cyc += 4;
          end
        end
        6'h08: begin
          if (w[20:16] != 0) m_rf[w[20:16]] = ad;
          cyc += 4;
        end
        6'h23: begin
          m_rd_q.push_back(ad);
          if (w[20:16] != 0) m_rf[w[20:16]] = m_mem[ad[11:2]];
          cyc += 5;
        end
        6'h2b: begin
          m_mem[ad[11:2]] = y;
          m_wr_addr_q.push_back(ad);
          m_wr_data_q.push_back(y);
          cyc += 4;
        end
        6'h04: begin
          if (x == y) mpc = mpc + (se << 2);
          cyc += 3;
        end
        6'h02: begin
          mpc = {mpc[31:28], w[25:0], 2'b00};
          cyc += 3;
        end
        default: done = 1;
      endcase
      if (done) cyc += 2;
    end
  endtask

  task automatic run_prog(input int budget, input int probe, output int cyc,
                          output logic [31:0] probe_pc, output bit timeout);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    rd_addr_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    reset = 1'b0;
    cyc = 0; probe_pc = 32'hxxxx_xxxx; timeout = 1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == probe) probe_pc = pc;
      if (halted === 1'b1) begin
        timeout = 0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clear_mem();
    mem[0] = enc_i(8, 0, 1, 1);
    mem[1] = HALT_WORD;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b0 || pc !== 32'd0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL reset_state req=%b pc=%h halted=%b required 0/00000000/0", mem_req, pc, halted);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'd0) begin
      failures++;
      $display("FAIL reset_first_fetch req=%b we=%b addr=%h required 1/0/00000000", mem_req, mem_we, mem_addr);
    end
  endtask

  task automatic test_basic();
    int cyc;
    logic [31:0] ppc;
    bit to;
    clear_mem();
    mem[0] = enc_i(8, 0, 1, 5);
    mem[1] = enc_i(8, 0, 2, 7);
    mem[2] = enc_r(32'h20, 1, 2, 3);
    mem[3] = enc_i(32'h2b, 0, 3, 32'h40);
    mem[4] = enc_i(32'h23, 0, 4, 32'h40);
    mem[5] = enc_i(32'h2b, 0, 4, 32'h44);
    mem[6] = HALT_WORD;
    run_prog(200, 12, cyc, ppc, to);
    checks++;
    if (ppc !== 32'h0c) begin
      failures++;
      $display("FAIL basic_pc_at_12 got=%h required=0000000c", ppc);
    end
    checks++;
    if (to || cyc != 27) begin
      failures++;
      $display("FAIL basic_cycles got=%0d timeout=%0d required=27", cyc, to);
    end
    checks++;
    if (wr_addr_q.size() != 2) begin
      failures++;
      $display("FAIL basic_write_count got=%0d required=2", wr_addr_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] !== 32'h40 || wr_data_q[0] !== 32'd12) begin
        failures++;
        $display("FAIL basic_sw got addr=%h data=%h required 00000040/0000000c", wr_addr_q[0], wr_data_q[0]);
      end
      checks++;
      if (wr_addr_q[1] !== 32'h44 || wr_data_q[1] !== 32'd12) begin
        failures++;
        $display("FAIL basic_lw_value got addr=%h data=%h required 00000044/0000000c", wr_addr_q[1], wr_data_q[1]);
      end
    end
  endtask

  task automatic test_fetch_stall();
    int held;
    bit seen;
    clear_mem();
    mem[0] = enc_i(8, 0, 1, 3);
    mem[1] = HALT_WORD;
    ready_mode = 2;
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    held = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      #1;
      if (mem_req === 1'b1 && mem_addr === 32'd0 && mem_we === 1'b0) held++;
      @(posedge clk); #1;
      if (i < 3) begin
        checks++;
        if (pc !== 32'd0) begin
          failures++;
          $display("FAIL stall_no_latch cycle=%0d pc=%h required=00000000", i, pc);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (held != 4) begin
      failures++;
      $display("FAIL stall_req_held got=%0d cycles required=4", held);
    end
    mem_ready = 1'b0;
    #1;
    checks++;
    if (pc !== 32'd4 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL stall_latched pc=%h req=%b required 00000004/0", pc, mem_req);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'd4) begin
      failures++;
      $display("FAIL ready_ignored_idle req=%b addr=%h required 1/00000004", mem_req, mem_addr);
    end
    mem_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      if (halted === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL stall_halt_timeout halted=%b required=1", halted);
    end
    ready_mode = 0;
  endtask

  task automatic test_branch_jump();
    int cyc;
    logic [31:0] ppc;
    bit to, ok;
    clear_mem();
    mem[0] = enc_j(4);
    mem[4] = enc_i(4, 1, 1, 32'hffff_ffff);
    run_prog(15, 15, cyc, ppc, to);
    ok = (rd_addr_q.size() == 5);
    for (int i = 1; i < rd_addr_q.size(); i++) if (rd_addr_q[i] !== 32'h10) ok = 0;
    checks++;
    if (!ok || ppc !== 32'h10 || halted !== 1'b0) begin
      failures++;
      $display("FAIL beq_loop fetches=%0d pc=%h halted=%b required 5/00000010/0", rd_addr_q.size(), ppc, halted);
    end

    clear_mem();
    mem[0]   = enc_i(8, 0, 1, 1);
    mem[1]   = enc_j(4);
    mem[4]   = enc_i(4, 1, 0, 3);
    mem[5]   = enc_j(32'h100);
    mem[256] = HALT_WORD;
    run_prog(100, 10, cyc, ppc, to);
    checks++;
    if (ppc !== 32'h14) begin
      failures++;
      $display("FAIL beq_not_taken pc=%h required=00000014", ppc);
    end
    checks++;
    if (to || cyc != 15 || pc !== 32'h404) begin
      failures++;
      $display("FAIL jump_cycles cyc=%0d pc=%h required 15/00000404", cyc, pc);
    end
    ok = (rd_addr_q.size() == 5);
    if (ok) ok = (rd_addr_q[0] === 32'h0 && rd_addr_q[1] === 32'h4 && rd_addr_q[2] === 32'h10 &&
                  rd_addr_q[3] === 32'h14 && rd_addr_q[4] === 32'h400);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL jump_trace fetches=%0d required 0,4,10,14,400", rd_addr_q.size());
    end
  endtask

  task automatic test_halt();
    int cyc, bad;
    logic [31:0] ppc;
    bit to;
    clear_mem();
    mem[0] = HALT_WORD;
    run_prog(20, 0, cyc, ppc, to);
    checks++;
    if (to || cyc != 2) begin
      failures++;
      $display("FAIL halt_opcode cyc=%0d timeout=%0d required 2/0", cyc, to);
    end
    ready_mode = 1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (halted !== 1'b1 || mem_req !== 1'b0 || pc !== 32'd4) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL halt_persist bad_cycles=%0d required=0 (halted=%b req=%b pc=%h)", bad, halted, mem_req, pc);
    end
    ready_mode = 0;
    mem[0] = enc_r(32'h21, 1, 2, 3);
    run_prog(20, 0, cyc, ppc, to);
    checks++;
    if (to || cyc != 2) begin
      failures++;
      $display("FAIL halt_funct cyc=%0d timeout=%0d required 2/0", cyc, to);
    end
  endtask

  task automatic test_reset_mid_write();
    bit found;
    clear_mem();
    mem[0] = enc_i(8, 0, 1, 9);
    mem[1] = enc_i(32'h2b, 0, 1, 32'h80);
    mem[2] = HALT_WORD;
    ready_mode = 2;
    mem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    wr_addr_q.delete(); wr_data_q.delete();
    reset = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #1;
      if (mem_req === 1'b1 && mem_we === 1'b1) begin
        found = 1;
        mem_ready = 1'b0;
      end
    end
    checks++;
    if (!found || mem_addr !== 32'h80 || mem_wdata !== 32'd9) begin
      failures++;
      $display("FAIL memwr_reached found=%0d addr=%h wdata=%h required 1/00000080/00000009", found, mem_addr, mem_wdata);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_drops_req req=%b required=0", mem_req);
    end
    @(posedge clk); #1;
    checks++;
    if (pc !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_pc pc=%h required=00000000", pc);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_fetch req=%b we=%b addr=%h required 1/0/00000000", mem_req, mem_we, mem_addr);
    end
    checks++;
    if (wr_addr_q.size() != 0 || mem[32] !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_no_write writes=%0d mem80=%h required 0/00000000", wr_addr_q.size(), mem[32]);
    end
    ready_mode = 0;
  endtask

  task automatic test_random();
    int n, k, s, t, d, cyc, mcyc;
    logic [31:0] ppc, fn;
    bit to, ok;
    for (int p = 0; p < 6; p++) begin
      clear_mem();
      for (int i = 128; i < 192; i++) mem[i] = $urandom;
      n = 0;
      mem[n++] = enc_i(8, 0, 7, 32'h200);
      for (int i = 0; i < 24; i++) begin
        k = $urandom_range(0, 8);
        s = $urandom_range(0, 7);
        t = $urandom_range(1, 6);
        d = $urandom_range(1, 6);
        case (k)
          0: mem[n++] = enc_i(8, s, t, $urandom);
          1, 2, 3, 4, 5: begin
            case (k)
              1: fn = 32'h20;
              2: fn = 32'h22;
              3: fn = 32'h24;
              4: fn = 32'h25;
              default: fn = 32'h2a;
            endcase
            mem[n++] = enc_r(fn, s, $urandom_range(0, 7), d);
          end
          6: mem[n++] = enc_i(32'h23, 7, t, 4 * $urandom_range(0, 63));
          7: mem[n++] = enc_i(32'h2b, 7, $urandom_range(0, 7), 4 * $urandom_range(0, 63));
          default: mem[n++] = enc_i(4, s, $urandom_range(0, 7), $urandom_range(0, 2));
        endcase
      end
      for (int r = 1; r < 8; r++) mem[n++] = enc_i(32'h2b, 7, r, 32'h100 + 4 * r);
      mem[n++] = HALT_WORD;
      for (int i = 0; i < 1024; i++) m_mem[i] = mem[i];
      model_run(mcyc);
      ready_mode = p % 2;
      run_prog(3000, 0, cyc, ppc, to);
      ready_mode = 0;
      ok = !to && (rd_addr_q.size() == m_rd_q.size());
      if (ok) for (int i = 0; i < m_rd_q.size(); i++) if (rd_addr_q[i] !== m_rd_q[i]) ok = 0;
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL rand_read_trace prog=%0d reads=%0d timeout=%0d required reads=%0d", p, rd_addr_q.size(), to, m_rd_q.size());
      end
      ok = (wr_addr_q.size() == m_wr_addr_q.size());
      if (ok) for (int i = 0; i < m_wr_addr_q.size(); i++)
        if (wr_addr_q[i] !== m_wr_addr_q[i] || wr_data_q[i] !== m_wr_data_q[i]) ok = 0;
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL rand_write_trace prog=%0d writes=%0d required=%0d", p, wr_addr_q.size(), m_wr_addr_q.size());
      end
      if (ready_mode == 0 && p % 2 == 0) begin
        checks++;
        if (cyc != mcyc) begin
          failures++;
          $display("FAIL rand_cycles prog=%0d got=%0d required=%0d", p, cyc, mcyc);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_mem();
    test_reset();
    test_basic();
    test_fetch_stall();
    test_branch_jump();
    test_halt();
    test_reset_mid_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_mc.md
MIPS_MC -- requirements
Module: mips_mc

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter RF_CLEAR, default 1, meaning reset zeroes all 32 registers (0: registers keep their contents through reset).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port mem_req, output, 1 bit: memory transfer request.
REQ-006 SHALL have port mem_we, output, 1 bit: write (1) or read (0); valid while mem_req=1.
REQ-007 SHALL have port mem_addr, output, 32 bits: byte address of the transfer.
REQ-008 SHALL have port mem_wdata, output, 32 bits: store data.
REQ-009 SHALL have port mem_rdata, input, 32 bits: read data, sampled on the completing edge.
REQ-010 SHALL have port mem_ready, input, 1 bit: transfer completes on an edge where mem_req=1 and mem_ready=1.
REQ-011 SHALL have port pc, output, 32 bits: current PC register.
REQ-012 SHALL have port halted, output, 1 bit: core stopped on an illegal opcode.

Function
REQ-013 SHALL implement a multicycle MIPS core with one unified memory port, executing lw, sw, beq, addi, j, and R-type add, sub, and, or, slt.
REQ-014 SHALL sequence through FSM states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, HALT.
REQ-015 FETCH SHALL drive mem_req=1, mem_we=0, mem_addr=pc; on completion it SHALL latch IR<=mem_rdata and pc<=pc+4, then go to DECODE.
REQ-016 DECODE SHALL latch A<=rs and B<=rt, compute ALUOut<=pc+(signext(imm)<<2), and dispatch on opcode; any unlisted opcode or funct SHALL go to HALT.
REQ-017 MEMADR SHALL compute ALUOut<=A+signext(imm), then go to MEMRD (lw) or MEMWR (sw).
REQ-018 MEMRD SHALL perform a read at ALUOut and latch MDR; MEMWB SHALL write MDR to rt.
REQ-019 MEMWR SHALL perform a write at ALUOut with mem_wdata=B, then go to FETCH.
REQ-020 EXEC SHALL compute funct(A,B); ALUWB SHALL write the result to rd. ADDIEX SHALL compute A+signext(imm); ADDIWB SHALL write the result to rt.
REQ-021 BRANCH SHALL set pc<=ALUOut if A==B; JUMP SHALL set pc<={pc[31:28],imm26,2'b00}.
REQ-022 Every non-HALT terminal state SHALL return to FETCH.
REQ-023 While waiting, mem_req, mem_we, mem_addr and mem_wdata SHALL hold stable until the completing edge; mem_ready SHALL be ignored when mem_req=0.
REQ-024 With mem_ready tied to 1, cycle counts SHALL be: R-type 4, addi 4, lw 5, sw 4, beq 3, j 3. Each wait cycle adds 1.
REQ-025 Writes to register 0 SHALL be discarded, and register 0 SHALL read as 0.
REQ-026 Arithmetic SHALL be 32-bit modulo with no overflow trap; slt SHALL compare signed.
REQ-027 In HALT: halted=1, mem_req=0, and no state change until reset.

Reset
REQ-028 On an edge with reset=1: state<=FETCH, pc<=RESET_PC, IR/A/B/ALUOut/MDR<=0, halted<=0, and registers are cleared if RF_CLEAR=1.
REQ-029 mem_req SHALL be 0 while reset=1; a transfer in flight is abandoned without a write taking effect.
REQ-030 Reset SHALL take priority over every other event, including a completing transfer on the same edge.

Structure
REQ-031 Package mips_mc_pkg SHALL hold the opcode and funct constants, the FSM state enum and the ALU-operation enum.
REQ-032 The FSM SHALL be the sub-module mips_mc_ctrl (opcode, funct, state outputs); the datapath, register file and ALU SHALL stay in mips_mc.

Verification
REQ-033 Program addi $1,$0,5; addi $2,$0,7; add $3,$1,$2 with ready=1 -> $3=12, pc=0x0C after 12 cycles.
REQ-034 Program sw $3,0x40($0) then lw $4,0x40($0) -> write of 0x0000000C at address 0x40 seen on the port; $4=12.
REQ-035 Fetch with mem_ready low for 3 cycles -> mem_req/mem_addr held for 4 cycles; IR latched on the 4th.
REQ-036 beq $1,$1,-1 at 0x10 -> pc=0x10 repeatedly; beq with unequal operands -> pc=0x14; j 0x100 -> pc=0x400.
REQ-037 Opcode 6'h3F -> halted=1 and mem_req=0 persist; reset asserted mid-MEMWR with ready=0 -> no write occurs, pc=RESET_PC, and the next cycle is FETCH.
